instr_bank: RTL and testbench

Parametrised, writable instruction store for the CPU fetch path. It is the next generation of the fixed combinational opcode table. Software or a bench streams a program into it through a valid/ready load port, then the fetch stage reads opcodes through a registered, one-cycle-latency read port. The block tracks program length and flags out-of-range or out-of-mode fetches.

---
 rtl/instr_bank.sv | 102 ++++++++++
 tb/tb_instr_bank.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_bank.sv
// Writable instruction store: streamed load port plus a one-cycle registered fetch port.
// Fetches are gated by mode (RUN only) and by the loaded program length.
module instr_bank #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_ovf,
  output logic [ADDR_W:0]   prog_len,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     prog_len_reg;
  logic                ovf_reg;
  logic                rd_valid_reg;
  logic                rd_err_reg;
  logic [DATA_W-1:0]   mem_q_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                enter_load;
  logic                full;
  logic                accept;
  logic                drop;
  logic                rd_reject;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (load_en)  state_next = LOAD;
      LOAD:    if (!load_en) state_next = RUN;
      RUN:     if (load_en)  state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // The write pointer is prog_len itself, so clearing it on LOAD entry restarts the program.
  assign enter_load = (state_next == LOAD) && (state_reg != LOAD);
  assign full       = (prog_len_reg == DEPTH_L);
  assign load_ready = (state_reg == LOAD) && load_en && !full;
  assign accept     = load_ready && load_valid;
  assign drop       = (state_reg == LOAD) && load_en && load_valid && full;
  assign wr_idx     = prog_len_reg[IDX_W-1:0];

  assign rd_reject  = (state_reg != RUN) ||
                      ({1'b0, rd_addr} >= prog_len_reg) ||
                      ({1'b0, rd_addr} >= DEPTH_L);
  assign rd_idx     = rd_reject ? '0 : rd_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      prog_len_reg <= '0;
      ovf_reg      <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= rd_req;
      rd_err_reg   <= rd_req && rd_reject;
      if (enter_load) begin
        prog_len_reg <= '0;
        ovf_reg      <= 1'b0;
      end else begin
        if (accept) prog_len_reg <= prog_len_reg + (ADDR_W + 1)'(1);
        if (drop)   ovf_reg      <= 1'b1;
      end
    end
  end

  // Storage carries no reset so it can map onto block RAM; prog_len hides stale words.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx] <= load_data;
    if (rd_req) mem_q_reg   <= mem[rd_idx];
  end

  assign rd_valid = rd_valid_reg;
  assign rd_err   = rd_err_reg;
  assign rd_data  = (rd_valid_reg && !rd_err_reg) ? mem_q_reg : '0;
  assign prog_len = prog_len_reg;
  assign load_ovf = ovf_reg;
  assign busy     = (state_reg != RUN);

endmodule

// File: tb/tb_instr_bank.sv
// Directed bench for instr_bank with a 4-word store: reset, load, fetch, overflow,
// reload and source backpressure, each result compared to hand-computed values.
module tb_instr_bank;

  logic       clk;
  logic       nrst;
  logic       load_en;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_ovf;
  logic [8:0] prog_len;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  instr_bank #(.ADDR_W(8), .DATA_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .load_en    (load_en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_ovf   (load_ovf),
    .prog_len   (prog_len),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_err     (rd_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] prog_a [4];
  int         exp_len;
  logic [7:0] nxt;

  initial begin
    prog_a[0] = 8'hA1; prog_a[1] = 8'hB2; prog_a[2] = 8'hC3; prog_a[3] = 8'hD4;
    nrst = 1'b0; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    rd_req = 1'b0; rd_addr = '0;

    #12;
    check("rst_busy", busy, 1);
    check("rst_ready", load_ready, 0);
    check("rst_len", prog_len, 0);
    check("rst_ovf", load_ovf, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_err", rd_err, 0);

    // Reset in the middle of a load
    @(negedge clk); nrst = 1'b1; load_en = 1'b1;
    tick;
    check("load_ready_on_entry", load_ready, 1);
    rd_req = 1'b1; rd_addr = 8'd0; load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = 8'(8'h11 * (i + 1));
      tick;
    end
    check("mid_len3", prog_len, 3);
    check("load_mode_valid", rd_valid, 1);
    check("load_mode_err", rd_err, 1);
    check("load_mode_data", rd_data, 0);
    #2 nrst = 1'b0;
    #1;
    check("async_len", prog_len, 0);
    check("async_valid", rd_valid, 0);
    check("async_err", rd_err, 0);
    check("async_busy", busy, 1);
    check("async_ready", load_ready, 0);
    load_valid = 1'b0; load_en = 1'b0; rd_req = 1'b0;
    @(negedge clk); nrst = 1'b1; rd_req = 1'b1; rd_addr = 8'd0;
    tick;
    check("idle_fetch_valid", rd_valid, 1);
    check("idle_fetch_err", rd_err, 1);
    rd_req = 1'b0;

    // Load A1..D4 and read back
    load_en = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = prog_a[i];
      #1 check("beat_ready", load_ready, 1);
      tick;
    end
    check("len4", prog_len, 4);
    check("full_ready", load_ready, 0);
    load_valid = 1'b0; load_en = 1'b0; rd_req = 1'b1; rd_addr = 8'd0;
    tick;
    check("edgeN_err", rd_err, 1);
    check("run_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i);
      tick;
      check("rb_valid", rd_valid, 1);
      check("rb_err", rd_err, 0);
      check("rb_data", rd_data, prog_a[i]);
    end
    rd_addr = 8'd4;
    tick;
    check("oor_valid", rd_valid, 1);
    check("oor_err", rd_err, 1);
    check("oor_data", rd_data, 0);
    rd_req = 1'b0;
    tick;
    check("valid_one_cycle", rd_valid, 0);

    // Full store: fetch on the RUN->LOAD edge is still a RUN read
    load_en = 1'b1; rd_req = 1'b1; rd_addr = 8'd2;
    tick;
    check("switch_fetch_err", rd_err, 0);
    check("switch_fetch_data", rd_data, 8'hC3);
    check("reload_len_clr", prog_len, 0);
    check("reload_busy", busy, 1);
    rd_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; load_data = 8'(8'h01 + i);
      #1 check("ovf_ready", load_ready, (i < 4) ? 1 : 0);
      tick;
    end
    check("ovf_len", prog_len, 4);
    check("ovf_flag", load_ovf, 1);
    load_valid = 1'b0; load_en = 1'b0;
    tick;
    rd_req = 1'b1; rd_addr = 8'd3;
    tick;
    check("ovf_addr3_err", rd_err, 0);
    check("ovf_addr3_data", rd_data, 8'h04);
    rd_req = 1'b0;

    // Reload one word
    load_en = 1'b1;
    tick;
    check("reload2_len", prog_len, 0);
    check("reload2_ovf", load_ovf, 0);
    load_valid = 1'b1; load_data = 8'h5E;
    tick;
    load_valid = 1'b0; load_en = 1'b0;
    tick;
    rd_req = 1'b1; rd_addr = 8'd0;
    tick;
    check("r5e_err", rd_err, 0);
    check("r5e_data", rd_data, 8'h5E);
    rd_addr = 8'd1;
    tick;
    check("r5e_a1_err", rd_err, 1);
    check("r5e_a1_data", rd_data, 0);
    rd_req = 1'b0;

    // Source backpressure: a beat every other cycle
    load_en = 1'b1;
    tick;
    exp_len = 0; nxt = 8'h70;
    for (int c = 0; c < 6; c++) begin
      load_valid = (c % 2 == 0);
      load_data  = nxt;
      tick;
      if (c % 2 == 0) begin
        exp_len++;
        nxt = nxt + 8'd1;
      end
      check("bp_len", prog_len, 32'(exp_len));
    end
    load_valid = 1'b0; load_en = 1'b0;
    tick;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i);
      tick;
      check("bp_err", rd_err, (i < 3) ? 1'b0 : 1'b1);
      check("bp_data", rd_data, (i < 3) ? 32'(8'h70 + i) : 32'd0);
    end
    rd_req = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
